m3_drive_sequencer: RTL and testbench

- Run-state controller for the 3-phase drive. Turns the operator command pulses (start, force-stop, invert-rotate, freq/power INC/DEC) into ramped setpoints for the power/speed calculation stage: current frequency, power level, direction and enable.
- Sequences soft start, soft stop and direction reversal: ramp down, dead-time, flip direction, ramp up.

---
 rtl/m3_drive_sequencer.sv | 176 +++++++++++++++++
 tb/tb_m3_drive_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/m3_drive_sequencer.sv
// m3_drive_sequencer: run-state controller turning operator command pulses into ramped
// frequency/power/direction/enable setpoints for the 3-phase drive calc stage.
module m3_drive_sequencer #(
  parameter int FREQ_W    = 16,
  parameter int PWR_W     = 8,
  parameter int FREQ_MIN  = 100,
  parameter int FREQ_MAX  = 4000,
  parameter int FREQ_DEF  = 1000,
  parameter int FREQ_STEP = 50,
  parameter int RAMP_DIV  = 1000,
  parameter int RAMP_STEP = 10,
  parameter int PWR_MIN   = 16,
  parameter int PWR_MAX   = 255,
  parameter int PWR_DEF   = 32,
  parameter int PWR_STEP  = 8,
  parameter int DEAD_CYC  = 500
) (
  input  logic              clkI,
  input  logic              nRstI,
  input  logic              m3startI,
  input  logic              m3forceStopI,
  input  logic              m3invRotateI,
  input  logic              m3freqINCi,
  input  logic              m3freqDECi,
  input  logic              m3powerINCi,
  input  logic              m3powerDECi,
  output logic [FREQ_W-1:0] m3freqTargetO,
  output logic [FREQ_W-1:0] m3freqCurO,
  output logic [PWR_W-1:0]  m3powerO,
  output logic              m3dirO,
  output logic              m3enableO,
  output logic [2:0]        m3stateO,
  output logic              m3busyO
);
  typedef enum logic [2:0] {IDLE = 3'd0, RAMP_UP = 3'd1, RUN = 3'd2, RAMP_DOWN = 3'd3, REVERSE = 3'd4} state_t;
  localparam int PW = $clog2(RAMP_DIV);
  localparam int DW = $clog2(DEAD_CYC + 1);
  localparam logic [FREQ_W:0] FMIN = (FREQ_W+1)'(FREQ_MIN);
  localparam logic [FREQ_W:0] FMAX = (FREQ_W+1)'(FREQ_MAX);
  localparam logic [FREQ_W:0] FSTEP = (FREQ_W+1)'(FREQ_STEP);
  localparam logic [FREQ_W:0] RSTEP = (FREQ_W+1)'(RAMP_STEP);
  localparam logic [PWR_W:0] PMIN = (PWR_W+1)'(PWR_MIN);
  localparam logic [PWR_W:0] PMAX = (PWR_W+1)'(PWR_MAX);
  localparam logic [PWR_W:0] PSTEP = (PWR_W+1)'(PWR_STEP);
  logic [6:0] cmd_q, prev_q, e;
  state_t state_q, state_d;
  logic [FREQ_W-1:0] cur_q, cur_d, tgt_q, tgt_d;
  logic [PWR_W-1:0] pwr_q, pwr_d, pout_q, pout_d;
  logic dir_q, dir_d, en_q, en_d, pend_q, pend_d, busy_q, busy_d, tick;
  logic [PW-1:0] pre_q, pre_d;
  logic [DW-1:0] dead_q, dead_d;
  logic [FREQ_W:0] cur_w, tgt_w, cur_up, up_clamp, run_next, f_inc, f_dec;
  logic [PWR_W:0] pwr_w, p_inc, p_dec;
  // bit order: start, forceStop, invRotate, freqINC, freqDEC, powerINC, powerDEC
  assign e = cmd_q & ~prev_q;
  assign cur_w = {1'b0, cur_q};
  assign tgt_w = {1'b0, tgt_q};
  assign pwr_w = {1'b0, pwr_q};
  assign tick = pre_q == PW'(RAMP_DIV - 1);
  assign cur_up = cur_w + RSTEP;
  assign up_clamp = cur_up > tgt_w ? tgt_w : cur_up;
  assign run_next = cur_w < tgt_w ? (tgt_w - cur_w > RSTEP ? cur_up : tgt_w)
                                  : (cur_w - tgt_w > RSTEP ? cur_w - RSTEP : tgt_w);
  // one bit of headroom keeps saturation checks free of wrap-around
  assign f_inc = tgt_w + FSTEP > FMAX ? FMAX : tgt_w + FSTEP;
  assign f_dec = tgt_w < FMIN + FSTEP ? FMIN : tgt_w - FSTEP;
  assign p_inc = pwr_w + PSTEP > PMAX ? PMAX : pwr_w + PSTEP;
  assign p_dec = pwr_w < PMIN + PSTEP ? PMIN : pwr_w - PSTEP;
  always_comb begin
    state_d = state_q;
    cur_d = cur_q;
    en_d = en_q;
    dir_d = dir_q;
    pend_d = pend_q;
    dead_d = '0;
    tgt_d = (e[3] ^ e[4]) ? (e[3] ? f_inc[FREQ_W-1:0] : f_dec[FREQ_W-1:0]) : tgt_q;
    pwr_d = (e[5] ^ e[6]) ? (e[5] ? p_inc[PWR_W-1:0] : p_dec[PWR_W-1:0]) : pwr_q;
    case (state_q)
      IDLE: begin
        cur_d = '0;
        en_d = 1'b0;
        if (e[0]) begin
          state_d = RAMP_UP;
          cur_d = FMIN[FREQ_W-1:0];
          en_d = 1'b1;
        end else if (e[2]) dir_d = ~dir_q;
      end
      RAMP_UP, RUN: begin
        if (e[0] | e[2]) begin
          state_d = RAMP_DOWN;
          pend_d = ~e[0];
        end else if (tick) begin
          cur_d = state_q == RAMP_UP ? up_clamp[FREQ_W-1:0] : run_next[FREQ_W-1:0];
          if (state_q == RAMP_UP && up_clamp == tgt_w) state_d = RUN;
        end
      end
      RAMP_DOWN: begin
        if (tick) begin
          if (cur_w <= FMIN + RSTEP) begin
            cur_d = '0;
            en_d = 1'b0;
            state_d = pend_q ? REVERSE : IDLE;
          end else cur_d = cur_q - RSTEP[FREQ_W-1:0];
        end
      end
      REVERSE: begin
        cur_d = '0;
        en_d = 1'b0;
        if (dead_q == DW'(DEAD_CYC - 1)) begin
          state_d = RAMP_UP;
          dir_d = ~dir_q;
          pend_d = 1'b0;
          cur_d = FMIN[FREQ_W-1:0];
          en_d = 1'b1;
        end else dead_d = dead_q + DW'(1);
      end
      default: begin
        state_d = IDLE;
        cur_d = '0;
        en_d = 1'b0;
      end
    endcase
    pre_d = (state_d != state_q || !(state_q inside {RAMP_UP, RUN, RAMP_DOWN}) || tick) ? '0 : pre_q + PW'(1);
    if (e[1]) begin
      state_d = IDLE;
      cur_d = '0;
      en_d = 1'b0;
      pend_d = 1'b0;
      pre_d = '0;
      dead_d = '0;
      tgt_d = tgt_q;
      pwr_d = pwr_q;
      dir_d = dir_q;
    end
    busy_d = state_d inside {RAMP_UP, RAMP_DOWN, REVERSE} || (state_d == RUN && cur_d != tgt_d);
    pout_d = en_d ? pwr_d : '0;
  end
  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      cmd_q <= '0;
      prev_q <= '0;
      state_q <= IDLE;
      tgt_q <= FREQ_W'(FREQ_DEF);
      cur_q <= '0;
      pwr_q <= PWR_W'(PWR_DEF);
      pout_q <= '0;
      dir_q <= 1'b0;
      en_q <= 1'b0;
      pend_q <= 1'b0;
      busy_q <= 1'b0;
      pre_q <= '0;
      dead_q <= '0;
    end else begin
      cmd_q <= {m3powerDECi, m3powerINCi, m3freqDECi, m3freqINCi, m3invRotateI, m3forceStopI, m3startI};
      prev_q <= cmd_q;
      state_q <= state_d;
      tgt_q <= tgt_d;
      cur_q <= cur_d;
      pwr_q <= pwr_d;
      pout_q <= pout_d;
      dir_q <= dir_d;
      en_q <= en_d;
      pend_q <= pend_d;
      busy_q <= busy_d;
      pre_q <= pre_d;
      dead_q <= dead_d;
    end
  end
  assign m3freqTargetO = tgt_q;
  assign m3freqCurO = cur_q;
  assign m3powerO = pout_q;
  assign m3dirO = dir_q;
  assign m3enableO = en_q;
  assign m3stateO = state_q;
  assign m3busyO = busy_q;
endmodule

// File: tb/tb_m3_drive_sequencer.sv
// tb_m3_drive_sequencer: directed scoreboard bench; expected snapshots and the expected
// sequence of freqCur changes (with spacing) are queued by stimulus and popped by a monitor.
module tb_m3_drive_sequencer;
  localparam int START = 1, FSTOP = 2, INV = 4, FINC = 8, FDEC = 16, PINC = 32, PDEC = 64;
  localparam int X = -1;
  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 0, fstop = 0, inv = 0, finc = 0, fdec = 0, pinc = 0, pdec = 0;
  logic [15:0] tgt_o, cur_o;
  logic [7:0] pwr_o;
  logic dir_o, en_o, busy_o;
  logic [2:0] st_o;
  m3_drive_sequencer #(.RAMP_DIV(4), .RAMP_STEP(10), .FREQ_MIN(100), .FREQ_DEF(150), .DEAD_CYC(3)) dut (
    .clkI(clk), .nRstI(rst_n), .m3startI(start), .m3forceStopI(fstop), .m3invRotateI(inv),
    .m3freqINCi(finc), .m3freqDECi(fdec), .m3powerINCi(pinc), .m3powerDECi(pdec),
    .m3freqTargetO(tgt_o), .m3freqCurO(cur_o), .m3powerO(pwr_o), .m3dirO(dir_o),
    .m3enableO(en_o), .m3stateO(st_o), .m3busyO(busy_o)
  );
  always #5 clk = ~clk;
  typedef struct {string name; int st, cur, tgt, pwr, dir, en, busy;} snap_t;
  typedef struct {int val; int gap;} ramp_t;
  snap_t snaps[$];
  ramp_t ramps[$];
  int vectors = 0, miscompares = 0, cyc = 0, last_cur = 0, last_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string n, int act, int exp);
    if (exp < 0) return;
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    snap_t s;
    ramp_t r;
    while (snaps.size() > 0) begin
      s = snaps.pop_front();
      chk({s.name, ".state"}, int'(st_o), s.st);
      chk({s.name, ".freqCur"}, int'(cur_o), s.cur);
      chk({s.name, ".freqTarget"}, int'(tgt_o), s.tgt);
      chk({s.name, ".power"}, int'(pwr_o), s.pwr);
      chk({s.name, ".dir"}, int'(dir_o), s.dir);
      chk({s.name, ".enable"}, int'(en_o), s.en);
      chk({s.name, ".busy"}, int'(busy_o), s.busy);
    end
    if (int'(cur_o) != last_cur) begin
      if (ramps.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL ramp.unexpected: freqCur changed to %0d, no change expected (cycle %0d)", cur_o, cyc);
      end else begin
        r = ramps.pop_front();
        chk("ramp.value", int'(cur_o), r.val);
        if (r.gap > 0) chk("ramp.spacing", cyc - last_cyc, r.gap);
      end
      last_cur = int'(cur_o);
      last_cyc = cyc;
    end
  end
  task automatic wait_cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pulse(int m);
    {pdec, pinc, fdec, finc, inv, fstop, start} = 7'(m);
    wait_cyc(1);
    {pdec, pinc, fdec, finc, inv, fstop, start} = '0;
    wait_cyc(1);
  endtask
  task automatic snap(string n, int st, int cur, int tgt, int pwr, int dir, int en, int busy);
    snaps.push_back('{n, st, cur, tgt, pwr, dir, en, busy});
  endtask
  task automatic ramp(int from, int to, int step, int first_gap);
    int g = first_gap;
    for (int v = from; step > 0 ? v <= to : v >= to; v += step) begin
      ramps.push_back('{v, g});
      g = 4;
    end
  endtask
  task automatic rampv(int v, int g);
    ramps.push_back('{v, g});
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: run exceeded time limit, %0d snapshots and %0d ramp values pending", snaps.size(), ramps.size());
    $fatal(1);
  end
  initial begin
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(1);
    snap("reset", 0, 0, 150, 0, 0, 0, 0);
    wait_cyc(1);
    ramp(100, 150, 10, 0);
    pulse(START);
    snap("t1.start", 1, 100, 150, 32, 0, 1, 1);
    wait_cyc(25);
    snap("t1.run", 2, 150, 150, 32, 0, 1, 0);
    ramp(160, 300, 10, 0);
    repeat (3) pulse(FINC);
    snap("t2.inc3", 2, X, 300, 32, 0, 1, 1);
    wait_cyc(70);
    snap("t2.settle", 2, 300, 300, 32, 0, 1, 0);
    ramp(310, 4000, 10, 0);
    repeat (200) pulse(FINC);
    snap("t2.clamp", 2, X, 4000, 32, 0, 1, 1);
    wait_cyc(1200);
    snap("t2.top", 2, 4000, 4000, 32, 0, 1, 0);
    ramp(3990, 150, -10, 0);
    repeat (77) pulse(FDEC);
    wait_cyc(1450);
    snap("t2.back", 2, 150, 150, 32, 0, 1, 0);
    ramp(140, 110, -10, 0);
    rampv(0, 4);
    rampv(100, 3);
    ramp(110, 150, 10, 4);
    pulse(INV);
    snap("t3.down", 3, 150, 150, 32, 0, 1, 1);
    wait_cyc(20);
    snap("t3.dead", 4, 0, 150, 0, 0, 0, 1);
    wait_cyc(3);
    snap("t3.flip", 1, 100, 150, 32, 1, 1, 1);
    wait_cyc(25);
    snap("t3.run", 2, 150, 150, 32, 1, 1, 0);
    ramp(140, 110, -10, 0);
    rampv(0, 4);
    pulse(START);
    snap("t4.soft", 3, 150, 150, 32, 1, 1, 1);
    wait_cyc(25);
    snap("t4.idle", 0, 0, 150, 0, 1, 0, 0);
    ramp(100, 120, 10, 0);
    rampv(0, 2);
    pulse(START);
    wait_cyc(8);
    snap("t4.mid", 1, 120, 150, 32, 1, 1, 1);
    pulse(FSTOP);
    snap("t4.fstop", 0, 0, 150, 0, 1, 0, 0);
    ramp(100, 150, 10, 0);
    pulse(START);
    wait_cyc(25);
    snap("t5.run", 2, 150, 150, 32, 1, 1, 0);
    repeat (30) pulse(PINC);
    snap("t5.pmax", 2, 150, 150, 255, 1, 1, 0);
    pulse(PINC | PDEC);
    snap("t5.pboth", 2, 150, 150, 255, 1, 1, 0);
    pulse(PDEC);
    snap("t5.pdec1", 2, 150, 150, 247, 1, 1, 0);
    repeat (39) pulse(PDEC);
    snap("t5.pmin", 2, 150, 150, 16, 1, 1, 0);
    pulse(PDEC);
    snap("t5.pminsat", 2, 150, 150, 16, 1, 1, 0);
    pulse(PINC);
    snap("t5.pinc1", 2, 150, 150, 24, 1, 1, 0);
    pulse(FINC | FDEC);
    snap("t5.fboth", 2, 150, 150, 24, 1, 1, 0);
    ramp(140, 110, -10, 0);
    rampv(0, 4);
    pulse(START | INV);
    snap("t6.down", 3, 150, 150, 24, 1, 1, 1);
    wait_cyc(25);
    snap("t6.idle", 0, 0, 150, 0, 1, 0, 0);
    pulse(INV);
    snap("t6.inv", 0, 0, 150, 0, 0, 0, 0);
    repeat (2) pulse(FDEC);
    snap("t6.fmin", 0, 0, 100, 0, 0, 0, 0);
    rampv(100, 0);
    pulse(START);
    snap("t6.lowstart", 1, 100, 100, 24, 0, 1, 1);
    wait_cyc(5);
    snap("t6.lowrun", 2, 100, 100, 24, 0, 1, 0);
    wait_cyc(3);
    chk("end.ramp_pending", ramps.size(), 0);
    chk("end.snap_pending", snaps.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
